// File: rtl/alu_muldiv_divider_if.sv
// Operand/result bundle between the execute stage and the iterative divider.
// The master (core) drives the launch fields; the slave (divider) returns status and result.
interface alu_muldiv_divider_if #(
    parameter int WIDTH = 32
);
    logic             Start_i;
    logic [1:0]       Op_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic             Busy_o;
    logic             Done_o;
    logic [WIDTH-1:0] Result_o;
    logic             Zero_o;

    modport master (
        output Start_i, Op_i, A_i, B_i,
        input  Busy_o, Done_o, Result_o, Zero_o
    );

    modport slave (
        input  Start_i, Op_i, A_i, B_i,
        output Busy_o, Done_o, Result_o, Zero_o
    );
endinterface

// File: rtl/alu_muldiv_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; optional macro DIV_FAST_SPECIAL_EN.
// Latency: Done_o WIDTH+1 cycles after launch (1 cycle for div-by-zero/overflow with the macro).
// Backpressure: none; Start_i is ignored while Busy_o is high, Start_i in DONE issues back-to-back.
module alu_muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_muldiv_divider_if.slave  div_if
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    // Launch-time decode of the incoming operands
    logic             l_signed, l_a_neg, l_b_neg, l_div_zero, l_ovf;
    logic [WIDTH-1:0] l_a_mag, l_b_mag;

    always_comb begin
        l_signed   = ~div_if.Op_i[0];
        l_a_neg    = l_signed & div_if.A_i[WIDTH-1];
        l_b_neg    = l_signed & div_if.B_i[WIDTH-1];
        l_a_mag    = l_a_neg ? (~div_if.A_i + 1'b1) : div_if.A_i;
        l_b_mag    = l_b_neg ? (~div_if.B_i + 1'b1) : div_if.B_i;
        l_div_zero = (div_if.B_i == '0);
        l_ovf      = l_signed && (div_if.A_i == MIN_NEG) && (div_if.B_i == '1);
    end

    // One restoring step; rem_sh needs an extra bit before the trial subtract
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_nx, quot_nx;
    logic [WIDTH-1:0] quot_fin, rem_fin, res_fin;

    always_comb begin
        rem_sh  = {rem_q, quot_q[WIDTH-1]};
        fits    = (rem_sh >= {1'b0, b_mag_q});
        rem_nx  = fits ? WIDTH'(rem_sh - {1'b0, b_mag_q}) : rem_sh[WIDTH-1:0];
        quot_nx = {quot_q[WIDTH-2:0], fits};

        quot_fin = q_neg_q ? (~quot_nx + 1'b1) : quot_nx;
        rem_fin  = r_neg_q ? (~rem_nx + 1'b1) : rem_nx;
        if (div_zero_q) begin
            quot_fin = '1;
            rem_fin  = a_q;
        end else if (ovf_q) begin
            quot_fin = MIN_NEG;
            rem_fin  = '0;
        end
        res_fin = op_q[1] ? rem_fin : quot_fin;
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic [WIDTH-1:0] l_spec;
    always_comb begin
        if (div_if.Op_i[1]) l_spec = l_div_zero ? div_if.A_i : '0;
        else                l_spec = l_div_zero ? '1 : div_if.A_i;
    end
`endif

    logic launch;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_mag_d    = b_mag_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        zero_d     = zero_q;
        launch     = 1'b0;

        case (state_q)
            IDLE: launch = div_if.Start_i;
            CALC: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    result_d = res_fin;
                    zero_d   = (res_fin == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
                launch  = div_if.Start_i;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            op_d       = div_if.Op_i;
            a_d        = div_if.A_i;
            b_mag_d    = l_b_mag;
            q_neg_d    = l_a_neg ^ l_b_neg;
            r_neg_d    = l_a_neg;
            div_zero_d = l_div_zero;
            ovf_d      = l_ovf;
            rem_d      = '0;
            quot_d     = l_a_mag;
            cnt_d      = CW'(WIDTH);
            state_d    = CALC;
`ifdef DIV_FAST_SPECIAL_EN
            if (l_div_zero || l_ovf) begin
                state_d  = DONE;
                result_d = l_spec;
                zero_d   = (l_spec == '0);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_mag_q    <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_mag_q    <= b_mag_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
        end
    end

    assign div_if.Busy_o   = (state_q == CALC);
    assign div_if.Done_o   = (state_q == DONE);
    assign div_if.Result_o = result_q;
    assign div_if.Zero_o   = zero_q;
endmodule
